rc4_sbox_ram: RTL
=================

Name: rc4_sbox_ram

Overview:
Responder side of the RC4 S-box memory interface. It owns the 256x8 state array that the RC4 crypt core reads and writes through its sbox_rd/sbox_wr/address/data ports. It also contains a built-in identity-fill sequencer that loads S[i]=i on request before key scheduling starts. It sits beside the crypt core at the top level, port-for-port opposite the core's S-box pins.

Parameters:
DW, 8, data width of each S-box entry
AW, 8, address width; depth is 2**AW (256)
WR_FIRST, 1, 1 = read of the address being written in the same cycle returns the new data (sbox_din); 0 = returns the old data

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
init_req  input  1  level; high in IDLE or READY starts the identity fill
sbox_rd  input  1  read strobe from crypt core
sbox_raddr  input  AW  read address
sbox_dout  output  DW  registered read data to crypt core
sbox_wr  input  1  write strobe from crypt core
sbox_waddr  input  AW  write address
sbox_din  input  DW  write data from crypt core
init_done  output  1  high while in READY (array holds a valid state)
fill_busy  output  1  high while in FILL
access_err  output  1  one-cycle pulse: sbox_rd or sbox_wr asserted during FILL

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, fill counter=0, sbox_dout=0, init_done=0, fill_busy=0, access_err=0. Array contents are not reset and are undefined until the first fill.
- FSM states: IDLE, FILL, READY.
  - IDLE -> FILL when init_req=1.
  - FILL: each cycle writes mem[cnt]=cnt and increments cnt. The write with cnt=2**AW-1 moves the FSM to READY and wraps cnt to 0.
  - READY -> FILL when init_req=1; cnt restarts at 0.
  - init_req is ignored during FILL. A fill is never restarted or extended.
- Fill timing: fill_busy is high for exactly 256 cycles. init_done rises on the cycle after the last fill write.
- Read port:
  - sbox_rd=1 in cycle N with address A: sbox_dout = mem[A] from the edge ending cycle N, so it is valid during cycle N+1. One-cycle latency.
  - sbox_dout holds its last value when sbox_rd=0.
- Write port: sbox_wr=1 writes sbox_din to mem[sbox_waddr] at the clock edge. Writes are accepted in IDLE and READY.
- Same-cycle read and write, same address: with WR_FIRST=1, sbox_dout=sbox_din; with WR_FIRST=0, sbox_dout=prior mem content. Different addresses: both complete independently.
- During FILL:
  - External writes are dropped.
  - External reads are dropped; sbox_dout holds.
  - access_err pulses high the following cycle for each cycle in which sbox_rd|sbox_wr=1.
- Address arithmetic: the fill counter is AW bits and wraps modulo 2**AW. Addresses are unsigned with no range check.
- Reset mid-fill: returns to IDLE immediately and init_done=0. The partially filled array is left as is; a new init_req is required.
- Simultaneous init_req and sbox_wr in READY: the write in that cycle is accepted, then FILL begins next cycle and overwrites it.

Test Plan:
- Reset, then pulse init_req for 1 cycle -> fill_busy high exactly 256 cycles; init_done=1 on cycle 257; reads of addresses 0x00, 0x7F, 0xFF return 0x00, 0x7F, 0xFF one cycle after sbox_rd.
- In READY, write 0xA5 to 0x10, then read 0x10 next cycle -> sbox_dout=0xA5 one cycle after the read strobe; with sbox_rd=0 afterwards, sbox_dout holds 0xA5.
- Same cycle: sbox_wr addr 0x20 data 0x3C and sbox_rd addr 0x20 (entry previously 0x20) -> sbox_dout=0x3C with WR_FIRST=1, 0x20 with WR_FIRST=0; a following read returns 0x3C.
- Assert sbox_wr (addr 0x05, data 0xFF) and sbox_rd during FILL -> access_err pulses once per offending cycle; after fill, mem[0x05] reads 0x05.
- Swap-style traffic in READY: read S[3], read S[9], then write S[3]=0x09 and S[9]=0x03 -> reads of 3 and 9 return 0x09 and 0x03. Then init_req -> after 256 cycles both entries are restored to 0x03 and 0x09.
- Drop rstn at fill cycle 100 -> outputs go to reset values immediately and FSM is IDLE; a new init_req completes a full 256-cycle fill.

Source files
------------

// File: rtl/rc4_sbox_ram.sv
// RC4 S-box state memory: 2**AW x DW array serving the crypt core's read/write
// ports, with a built-in identity-fill sequencer (S[i] = i) ahead of key scheduling.
module rc4_sbox_ram #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter bit          WR_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          init_req,
  input  logic          sbox_rd,
  input  logic [AW-1:0] sbox_raddr,
  output logic [DW-1:0] sbox_dout,
  input  logic          sbox_wr,
  input  logic [AW-1:0] sbox_waddr,
  input  logic [DW-1:0] sbox_din,
  output logic          init_done,
  output logic          fill_busy,
  output logic          access_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data;

  // Same-address collision: bypass the incoming write data when WR_FIRST is set
  always_comb begin
    rd_data = mem[sbox_raddr];
    if (WR_FIRST && sbox_wr && (sbox_waddr == sbox_raddr)) begin
      rd_data = sbox_din;
    end
  end

  // Array has no reset; the fill sequencer owns the write port while filling
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      mem[cnt] <= DW'(cnt);
    end else if (sbox_wr) begin
      mem[sbox_waddr] <= sbox_din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      sbox_dout  <= '0;
      init_done  <= 1'b0;
      fill_busy  <= 1'b0;
      access_err <= 1'b0;
    end else begin
      access_err <= 1'b0;
      unique case (state)
        IDLE, READY: begin
          if (sbox_rd) begin
            sbox_dout <= rd_data;
          end
          if (init_req) begin
            state     <= FILL;
            cnt       <= '0;
            fill_busy <= 1'b1;
            init_done <= 1'b0;
          end
        end
        FILL: begin
          access_err <= sbox_rd | sbox_wr;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= READY;
            fill_busy <= 1'b0;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
